backoff_ctl: RTL and testbench

- DCF/EDCA backoff engine in the xpu: consumes the contention-window exponent produced by the CW exponent logic and turns it into an actual channel-access wait.
- On a start request, draws a random slot count in [0, 2^cw_exp - 1] and waits AIFS of continuous idle.
- Counts slots down while the channel is idle and freezes on busy, re-arming AIFS after every busy period.
- Pulses backoff_done when the wait completes; the tx path then launches or retries the frame.

---
 rtl/backoff_ctl.sv | 122 ++++++++++++
 tb/tb_backoff_ctl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/backoff_ctl.sv
// DCF/EDCA backoff engine: draws a random slot count from a 16-bit Galois LFSR,
// waits AIFS of continuous idle, then counts slots down, freezing while the medium is busy.
module backoff_ctl #(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          CW_EXP_MAX = 10,
    parameter int          TIME_WIDTH = 14
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_backoff,
    input  logic                  abort,
    input  logic [3:0]            cw_exp,
    input  logic                  ch_idle,
    input  logic [TIME_WIDTH-1:0] aifs_time,
    input  logic [TIME_WIDTH-1:0] slot_time,
    output logic                  backoff_busy,
    output logic                  backoff_done,
    output logic [CW_EXP_MAX-1:0] slot_remain,
    output logic [1:0]            bo_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AIFS = 2'd1,
        S_SLOT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [TIME_WIDTH-1:0]   timer_q, timer_d;
    logic [CW_EXP_MAX-1:0]   slot_q, slot_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic [4:0]              e_eff;
    logic [CW_EXP_MAX-1:0]   mask;
    logic [TIME_WIDTH-1:0]   aifs_last, slot_last;

    // Galois form of x^16+x^14+x^13+x^11+1; free-running so the draw depends on start timing.
    assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

    assign e_eff = ({1'b0, cw_exp} > 5'(CW_EXP_MAX)) ? 5'(CW_EXP_MAX) : {1'b0, cw_exp};

    generate
        for (genvar gi = 0; gi < CW_EXP_MAX; gi++) begin : g_mask
            assign mask[gi] = (5'(gi) < e_eff);
        end
    endgenerate

    // A zero-length interval behaves as one cycle.
    assign aifs_last = (aifs_time == '0) ? '0 : aifs_time - 1'b1;
    assign slot_last = (slot_time == '0) ? '0 : slot_time - 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            slot_q  <= '0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            slot_q  <= slot_d;
            lfsr_q  <= lfsr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        slot_d  = slot_q;
        if (abort) begin
            state_d = S_IDLE;
            timer_d = '0;
            slot_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_backoff) begin
                        slot_d  = lfsr_q[CW_EXP_MAX-1:0] & mask;
                        timer_d = '0;
                        state_d = S_AIFS;
                    end
                end
                S_AIFS: begin
                    if (!ch_idle) begin
                        timer_d = '0;
                    end else if (timer_q == aifs_last) begin
                        timer_d = '0;
                        state_d = (slot_q == '0) ? S_DONE : S_SLOT;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_SLOT: begin
                    // Busy discards the partial slot and re-arms a full AIFS.
                    if (!ch_idle) begin
                        timer_d = '0;
                        state_d = S_AIFS;
                    end else if (timer_q == slot_last) begin
                        timer_d = '0;
                        slot_d  = slot_q - 1'b1;
                        if (slot_q == CW_EXP_MAX'(1)) begin
                            state_d = S_DONE;
                        end
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        backoff_busy = (state_q != S_IDLE);
        backoff_done = (state_q == S_DONE) && !abort;
        bo_state     = state_q;
        slot_remain  = slot_q;
    end

endmodule

// File: tb/tb_backoff_ctl.sv
// Randomized self-checking bench for backoff_ctl: per-cycle expectations come from a
// timeline built out of the idle/busy pattern, the drawn slot count and the interval lengths.
module tb_backoff_ctl;
    localparam int TW   = 14;
    localparam int CWM  = 10;
    localparam int MAXC = 4096;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start_backoff = 1'b0;
    logic            abort = 1'b0;
    logic [3:0]      cw_exp = '0;
    logic            ch_idle = 1'b1;
    logic [TW-1:0]   aifs_time = TW'(1);
    logic [TW-1:0]   slot_time = TW'(1);
    logic            backoff_busy, backoff_done;
    logic [CWM-1:0]  slot_remain;
    logic [1:0]      bo_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] m_lfsr;
    bit idle_pat [MAXC];
    int exp_st   [MAXC];
    int exp_sr   [MAXC];

    backoff_ctl #(.LFSR_SEED(16'hACE1), .CW_EXP_MAX(CWM), .TIME_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .start_backoff(start_backoff), .abort(abort),
        .cw_exp(cw_exp), .ch_idle(ch_idle), .aifs_time(aifs_time), .slot_time(slot_time),
        .backoff_busy(backoff_busy), .backoff_done(backoff_done),
        .slot_remain(slot_remain), .bo_state(bo_state)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m_lfsr <= 16'hACE1;
        else     m_lfsr <= lfsr_step(m_lfsr);
    end

    task automatic chk(input string tag, input int obs, input int expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Expected state/slot count per cycle relative to the start cycle (0).
    task automatic build(input int k, input int a, input int s, output int done_c);
        int c;
        int left;
        int run;
        bit hit;
        c = 1;
        left = k;
        forever begin
            run = 0;
            while (run < a && c < MAXC - 2) begin
                exp_st[c] = 1; exp_sr[c] = left;
                run = idle_pat[c] ? run + 1 : 0;
                c++;
            end
            if (left == 0 || c >= MAXC - 2) break;
            run = 0; hit = 0;
            while (left > 0 && !hit && c < MAXC - 2) begin
                exp_st[c] = 2; exp_sr[c] = left;
                if (!idle_pat[c]) hit = 1;
                else begin
                    run++;
                    if (run == s) begin run = 0; left--; end
                end
                c++;
            end
            if (!hit || c >= MAXC - 2) break;
        end
        exp_st[c] = 3; exp_sr[c] = 0;
        done_c = c;
    endtask

    task automatic run_backoff(input int cw, input int a, input int s, input bit rnd_busy,
                               input bit mid_busy, input bit rnd_start, input int min_k);
        int ae, se, e, k, done_c, tries, busy_at;
        ae = (a == 0) ? 1 : a;
        se = (s == 0) ? 1 : s;
        e  = (cw > CWM) ? CWM : cw;
        for (int i = 0; i < MAXC; i++) idle_pat[i] = rnd_busy ? ($urandom_range(7) != 0) : 1'b1;
        @(negedge clk);
        tries = 0;
        while ((int'(m_lfsr) & ((1 << e) - 1)) < min_k && tries < 300) begin
            @(negedge clk);
            tries++;
        end
        k = int'(m_lfsr) & ((1 << e) - 1);
        if (mid_busy && k >= 4) begin
            busy_at = ae + 1 + (k - 4) * se + 1;
            for (int i = busy_at; i < busy_at + 5; i++) idle_pat[i] = 1'b0;
        end
        start_backoff = 1'b1;
        cw_exp    = cw[3:0];
        aifs_time = TW'(a);
        slot_time = TW'(s);
        ch_idle   = idle_pat[0];
        build(k, ae, se, done_c);
        if (!rnd_busy && !mid_busy) chk("done_latency", done_c, ae + k * se + 1);
        for (int c = 1; c <= done_c + 1; c++) begin
            @(negedge clk);
            start_backoff = rnd_start && (c <= done_c) && ($urandom_range(3) == 0);
            ch_idle = idle_pat[c];
            if (c <= done_c) begin
                chk("bo_state", int'(bo_state), exp_st[c]);
                chk("slot_remain", int'(slot_remain), exp_sr[c]);
                chk("backoff_busy", int'(backoff_busy), 1);
                chk("backoff_done", int'(backoff_done), (c == done_c) ? 1 : 0);
            end else begin
                chk("end_state", int'(bo_state), 0);
                chk("end_busy", int'(backoff_busy), 0);
                chk("end_done", int'(backoff_done), 0);
            end
        end
        start_backoff = 1'b0;
        ch_idle = 1'b1;
        $display("backoff cw=%0d aifs=%0d slot=%0d K=%0d done at +%0d errors=%0d",
                 cw, a, s, k, done_c, n_errors);
    endtask

    task automatic abort_slot;
        int tries;
        @(negedge clk);
        tries = 0;
        while ((m_lfsr & 16'h000F) == 0 && tries < 50) begin @(negedge clk); tries++; end
        start_backoff = 1'b1; cw_exp = 4'd4; aifs_time = TW'(1); slot_time = TW'(50); ch_idle = 1'b1;
        @(negedge clk); start_backoff = 1'b0;
        @(negedge clk);
        chk("abort_pre_state", int'(bo_state), 2);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_state", int'(bo_state), 0);
        chk("abort_slot", int'(slot_remain), 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("abort_no_done", int'(backoff_done), 0);
        end
        $display("abort in SLOT_CNT errors=%0d", n_errors);
    endtask

    task automatic abort_with_start;
        @(negedge clk);
        start_backoff = 1'b1; abort = 1'b1; cw_exp = 4'd5;
        @(negedge clk);
        start_backoff = 1'b0; abort = 1'b0;
        chk("abst_state", int'(bo_state), 0);
        chk("abst_slot", int'(slot_remain), 0);
        chk("abst_busy", int'(backoff_busy), 0);
        $display("abort+start in IDLE errors=%0d", n_errors);
    endtask

    task automatic big_exp(input int cw);
        int kx;
        @(negedge clk);
        kx = int'(m_lfsr) & 32'h3FF;
        start_backoff = 1'b1; cw_exp = cw[3:0]; aifs_time = TW'(3); slot_time = TW'(1);
        @(negedge clk);
        start_backoff = 1'b0;
        chk("clamp_draw", int'(slot_remain), kx);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("clamp_abort_state", int'(bo_state), 0);
        $display("cw_exp=%0d draw=%0d expected=%0d", cw, slot_remain, kx);
    endtask

    task automatic reset_mid;
        @(negedge clk);
        start_backoff = 1'b1; cw_exp = 4'd3; aifs_time = TW'(8); slot_time = TW'(3);
        @(negedge clk);
        start_backoff = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_state", int'(bo_state), 0);
        chk("rst_busy", int'(backoff_busy), 0);
        chk("rst_slot", int'(slot_remain), 0);
        chk("rst_done", int'(backoff_done), 0);
        @(negedge clk);
        rst = 1'b0;
        $display("async reset mid-AIFS errors=%0d", n_errors);
    endtask

    initial begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", int'(bo_state), 0);
        chk("reset_busy", int'(backoff_busy), 0);
        chk("reset_done", int'(backoff_done), 0);
        chk("reset_slot", int'(slot_remain), 0);
        rst = 1'b0;
        // Start lands in the first cycle after reset release.
        run_backoff(0, 4, 9, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) run_backoff(3, 2, 3, 0, 0, 0, 0);
        run_backoff(3, 2, 3, 0, 1, 0, 4);
        for (int i = 0; i < 20; i++)
            run_backoff($urandom_range(4), $urandom_range(6), $urandom_range(5), 1, 0, 1, 0);
        run_backoff(2, 0, 0, 0, 0, 0, 0);
        abort_slot();
        abort_with_start();
        for (int i = 0; i < 6; i++) big_exp(11 + (i % 5));
        reset_mid();
        run_backoff(3, 2, 3, 0, 0, 1, 1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
